// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default configuration constants and an index-width helper.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_DRAIN   = 2'd1,
    IRQ_ACK     = 2'd2,
    IRQ_SERVICE = 2'd3
  } irq_state_e;

  localparam int unsigned IRQ_NIRQ_DEFAULT       = 4;
  localparam int unsigned IRQ_IDN_BASE_DEFAULT   = 0;
  // Widest supported source count is 16; the top slices this to NIRQ bits.
  localparam logic [15:0] IRQ_MASK_RESET_DEFAULT = 16'hFFFF;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned irq_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Lowest-index-first priority encoder: source 0 wins over every other source.
module irq_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter  int unsigned NIRQ = IRQ_NIRQ_DEFAULT,
  localparam int unsigned IDXW = irq_idx_width(NIRQ)
) (
  input  logic [NIRQ-1:0] req,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDXW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches device requests as pending, picks the
// lowest-index enabled source, stalls fetch until the pipeline drains,
// then issues a one-cycle inta with the device number and waits for RETI.
//
// Optional build macro IRQ_EDGE_DETECT_EN: pend bits are set only on a
// 0->1 transition of the request line instead of on every high cycle.
//
// Handshake: there is no valid/ready pair here. inta is a single-cycle
// strobe; idn is only meaningful in the cycle where inta=1 and is held
// otherwise. isReti is honoured only while in service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned      DBITS      = 32,
  parameter int unsigned      NIRQ       = IRQ_NIRQ_DEFAULT,
  parameter int unsigned      IDN_BASE   = IRQ_IDN_BASE_DEFAULT,
  parameter logic [NIRQ-1:0]  MASK_RESET = IRQ_MASK_RESET_DEFAULT[NIRQ-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irqIn,
  input  logic             ieIn,
  input  logic             pipeEmpty,
  input  logic             isReti,
  input  logic             maskWrEn,
  input  logic [NIRQ-1:0]  maskIn,
  output logic             stallFetch,
  output logic             inta,
  output logic [DBITS-1:0] idn,
  output logic [NIRQ-1:0]  maskOut,
  output logic [NIRQ-1:0]  pendOut,
  output logic             busy
);

  localparam int unsigned IDXW = irq_idx_width(NIRQ);

  irq_state_e       state_q, state_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  mask_q, mask_d;
  logic             stall_q, stall_d;
  logic             inta_q, inta_d;
  logic             busy_q, busy_d;
  logic [DBITS-1:0] idn_q, idn_d;
  logic [IDXW-1:0]  winner_q, winner_d;

  logic [NIRQ-1:0]  elig;
  logic [NIRQ-1:0]  req_set;
  logic [NIRQ-1:0]  ack_clr;
  logic [IDXW-1:0]  win_idx;
  logic             win_valid;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NIRQ-1:0]  prev_q, prev_d;

  // Only a rising edge of a request line raises its pending bit.
  always_comb begin
    prev_d  = irqIn;
    req_set = irqIn & ~prev_q;
  end

  // Previous request sample used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= prev_d;
  end
`else
  // Level capture: a high request line re-pends every cycle.
  always_comb begin
    req_set = irqIn;
  end
`endif

  assign elig = pend_q & mask_q;

  irq_priority_encoder #(
    .NIRQ (NIRQ)
  ) u_prio (
    .req   (elig),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Acknowledged source is cleared at the end of ACK; a same-cycle set wins.
  always_comb begin
    ack_clr = '0;
    if (state_q == IRQ_ACK) ack_clr[winner_q] = 1'b1;
    pend_d = (pend_q & ~ack_clr) | req_set;
    mask_d = maskWrEn ? maskIn : mask_q;
  end

  // Next-state logic; the winner is re-evaluated every DRAIN cycle and
  // frozen only when moving into ACK. Outputs are derived from next state
  // so they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    idn_d    = idn_q;
    case (state_q)
      IRQ_IDLE: begin
        if (ieIn && win_valid) state_d = IRQ_DRAIN;
      end
      IRQ_DRAIN: begin
        if (!ieIn || !win_valid) begin
          state_d = IRQ_IDLE;
        end else if (pipeEmpty) begin
          state_d  = IRQ_ACK;
          winner_d = win_idx;
          idn_d    = DBITS'(IDN_BASE) + DBITS'(win_idx);
        end
      end
      IRQ_ACK: begin
        state_d = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (isReti) state_d = IRQ_IDLE;
      end
      default: begin
        state_d = IRQ_IDLE;
      end
    endcase
    stall_d = (state_d == IRQ_DRAIN) || (state_d == IRQ_ACK);
    inta_d  = (state_d == IRQ_ACK);
    busy_d  = (state_d != IRQ_IDLE);
  end

  // All controller state, including registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IRQ_IDLE;
      pend_q   <= '0;
      mask_q   <= MASK_RESET;
      stall_q  <= 1'b0;
      inta_q   <= 1'b0;
      busy_q   <= 1'b0;
      idn_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      stall_q  <= stall_d;
      inta_q   <= inta_d;
      busy_q   <= busy_d;
      idn_q    <= idn_d;
      winner_q <= winner_d;
    end
  end

  assign stallFetch = stall_q;
  assign inta       = inta_q;
  assign idn        = idn_q;
  assign maskOut    = mask_q;
  assign pendOut    = pend_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller (NIRQ=4, IDN_BASE=0, DBITS=32).
module tb_interrupt_controller;

  localparam int NIRQ  = 4;
  localparam int DBITS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NIRQ-1:0]  irqIn;
  logic             ieIn;
  logic             pipeEmpty;
  logic             isReti;
  logic             maskWrEn;
  logic [NIRQ-1:0]  maskIn;
  logic             stallFetch;
  logic             inta;
  logic [DBITS-1:0] idn;
  logic [NIRQ-1:0]  maskOut;
  logic [NIRQ-1:0]  pendOut;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [DBITS-1:0] exp_q[$];

  interrupt_controller #(
    .DBITS (DBITS),
    .NIRQ  (NIRQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irqIn      (irqIn),
    .ieIn       (ieIn),
    .pipeEmpty  (pipeEmpty),
    .isReti     (isReti),
    .maskWrEn   (maskWrEn),
    .maskIn     (maskIn),
    .stallFetch (stallFetch),
    .inta       (inta),
    .idn        (idn),
    .maskOut    (maskOut),
    .pendOut    (pendOut),
    .busy       (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs set after this apply at the next edge,
  // outputs read after this are the values registered at this edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irqIn = '0; ieIn = 1'b0; pipeEmpty = 1'b0;
    isReti = 1'b0; maskWrEn = 1'b0; maskIn = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic write_mask(input logic [NIRQ-1:0] m);
    maskWrEn = 1'b1; maskIn = m;
    tick();
    maskWrEn = 1'b0;
  endtask

  task automatic pulse_irq(input logic [NIRQ-1:0] r);
    irqIn = r;
    tick();
    irqIn = '0;
  endtask

  task automatic do_reti();
    isReti = 1'b1;
    tick();
    isReti = 1'b0;
  endtask

  // Bounded wait for an inta strobe; caller decides what was expected.
  task automatic wait_inta(input int max_cycles, output bit seen, output logic [DBITS-1:0] id);
    seen = 1'b0;
    id   = '0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      tick();
      if (inta === 1'b1) begin
        seen = 1'b1;
        id   = idn;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (stallFetch !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stallFetch); end
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL reset_inta: got %b exp 0", inta); end
    checks++; if (idn !== 32'd0) begin errors++; $display("FAIL reset_idn: got %0d exp 0", idn); end
    checks++; if (pendOut !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b exp 0000", pendOut); end
    checks++; if (maskOut !== 4'b1111) begin errors++; $display("FAIL reset_mask: got %b exp 1111", maskOut); end
  endtask

  // Single source with pipeline already empty: DRAIN then ACK, two stall cycles.
  task automatic test_basic();
    int stall_cycles;
    ieIn = 1'b1; pipeEmpty = 1'b1;
    pulse_irq(4'b0100);
    checks++; if (pendOut !== 4'b0100) begin errors++; $display("FAIL basic_pend_set: got %b exp 0100", pendOut); end
    checks++; if (stallFetch !== 1'b0) begin errors++; $display("FAIL basic_stall_c0: got %b exp 0", stallFetch); end
    stall_cycles = 0;
    tick();
    checks++; if (stallFetch !== 1'b1 || inta !== 1'b0) begin errors++; $display("FAIL basic_drain: got stall=%b inta=%b exp stall=1 inta=0", stallFetch, inta); end
    if (stallFetch === 1'b1) stall_cycles++;
    tick();
    checks++; if (inta !== 1'b1 || idn !== 32'd2) begin errors++; $display("FAIL basic_ack: got inta=%b idn=%0d exp inta=1 idn=2", inta, idn); end
    if (stallFetch === 1'b1) stall_cycles++;
    tick();
    if (stallFetch === 1'b1) stall_cycles++;
    checks++; if (stall_cycles != 2) begin errors++; $display("FAIL basic_stall_len: got %0d exp 2", stall_cycles); end
    checks++; if (pendOut !== 4'b0000 || inta !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_service: got pend=%b inta=%b busy=%b exp pend=0000 inta=0 busy=1", pendOut, inta, busy); end
    do_reti();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_reti: got busy=%b exp 0", busy); end
  endtask

  // Two sources together with a slow drain: lower index first, then the other.
  task automatic test_priority_drain();
    bit seen;
    logic [DBITS-1:0] id;
    ieIn = 1'b1; pipeEmpty = 1'b0;
    pulse_irq(4'b1010);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (stallFetch !== 1'b1 || inta !== 1'b0) begin errors++; $display("FAIL prio_drain_c%0d: got stall=%b inta=%b exp stall=1 inta=0", c, stallFetch, inta); end
    end
    pipeEmpty = 1'b1;
    wait_inta(3, seen, id);
    checks++; if (!seen || id !== 32'd1) begin errors++; $display("FAIL prio_first: got seen=%b idn=%0d exp seen=1 idn=1", seen, id); end
    tick();
    do_reti();
    wait_inta(6, seen, id);
    checks++; if (!seen || id !== 32'd3) begin errors++; $display("FAIL prio_second: got seen=%b idn=%0d exp seen=1 idn=3", seen, id); end
    tick();
    do_reti();
    checks++; if (pendOut !== 4'b0000) begin errors++; $display("FAIL prio_pend_empty: got %b exp 0000", pendOut); end
  endtask

  // Masked source stays pending without starting a drain until unmasked.
  task automatic test_mask();
    bit seen;
    logic [DBITS-1:0] id;
    ieIn = 1'b1; pipeEmpty = 1'b1;
    write_mask(4'b1110);
    checks++; if (maskOut !== 4'b1110) begin errors++; $display("FAIL mask_write: got %b exp 1110", maskOut); end
    pulse_irq(4'b0001);
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || stallFetch !== 1'b0) begin errors++; $display("FAIL mask_blocked: got busy=%b stall=%b exp 0 0", busy, stallFetch); end
    checks++; if (pendOut !== 4'b0001) begin errors++; $display("FAIL mask_pend_kept: got %b exp 0001", pendOut); end
    write_mask(4'b1111);
    wait_inta(5, seen, id);
    checks++; if (!seen || id !== 32'd0) begin errors++; $display("FAIL mask_release: got seen=%b idn=%0d exp seen=1 idn=0", seen, id); end
    tick();
    do_reti();
  endtask

  // Global enable dropped mid-drain aborts the request, pend retained.
  task automatic test_ie_drop();
    bit seen;
    logic [DBITS-1:0] id;
    ieIn = 1'b1; pipeEmpty = 1'b0;
    pulse_irq(4'b0100);
    tick();
    checks++; if (stallFetch !== 1'b1) begin errors++; $display("FAIL iedrop_drain: got stall=%b exp 1", stallFetch); end
    ieIn = 1'b0;
    tick();
    checks++; if (stallFetch !== 1'b0 || busy !== 1'b0 || inta !== 1'b0) begin errors++; $display("FAIL iedrop_idle: got stall=%b busy=%b inta=%b exp 0 0 0", stallFetch, busy, inta); end
    checks++; if (pendOut !== 4'b0100) begin errors++; $display("FAIL iedrop_pend: got %b exp 0100", pendOut); end
    ieIn = 1'b1; pipeEmpty = 1'b1;
    wait_inta(5, seen, id);
    checks++; if (!seen || id !== 32'd2) begin errors++; $display("FAIL iedrop_resume: got seen=%b idn=%0d exp seen=1 idn=2", seen, id); end
    tick();
    do_reti();
  endtask

  // Reset landing during ACK returns everything to reset values.
  task automatic test_reset_in_ack();
    write_mask(4'b0110);
    ieIn = 1'b1; pipeEmpty = 1'b1;
    pulse_irq(4'b0010);
    tick();
    tick();
    checks++; if (inta !== 1'b1 || idn !== 32'd1) begin errors++; $display("FAIL rstack_in_ack: got inta=%b idn=%0d exp 1 1", inta, idn); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (inta !== 1'b0 || busy !== 1'b0 || stallFetch !== 1'b0) begin errors++; $display("FAIL rstack_ctrl: got inta=%b busy=%b stall=%b exp 0 0 0", inta, busy, stallFetch); end
    checks++; if (pendOut !== 4'b0000 || maskOut !== 4'b1111 || idn !== 32'd0) begin errors++; $display("FAIL rstack_regs: got pend=%b mask=%b idn=%0d exp 0000 1111 0", pendOut, maskOut, idn); end
  endtask

  // A request line held high across ACK and RETI.
  task automatic test_held_line();
    bit seen;
    logic [DBITS-1:0] id;
    ieIn = 1'b1; pipeEmpty = 1'b1;
    irqIn = 4'b0010;
    wait_inta(5, seen, id);
    checks++; if (!seen || id !== 32'd1) begin errors++; $display("FAIL held_first: got seen=%b idn=%0d exp seen=1 idn=1", seen, id); end
    tick();
    do_reti();
    wait_inta(8, seen, id);
`ifdef IRQ_EDGE_DETECT_EN
    checks++; if (seen) begin errors++; $display("FAIL held_second: got seen=%b exp seen=0", seen); end
`else
    checks++; if (!seen || id !== 32'd1) begin errors++; $display("FAIL held_second: got seen=%b idn=%0d exp seen=1 idn=1", seen, id); end
    tick();
    do_reti();
`endif
    irqIn = '0;
    do_reset();
  endtask

  // Random request set and mask: every enabled requester is acknowledged
  // once in ascending index order, masked ones remain pending.
  task automatic test_random();
    bit seen;
    logic [DBITS-1:0] id;
    logic [NIRQ-1:0] r, m;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      r = NIRQ'($urandom_range(0, 15));
      m = NIRQ'($urandom_range(0, 15));
      ieIn = 1'b1; pipeEmpty = 1'b0;
      write_mask(m);
      exp_q.delete();
      for (int i = 0; i < NIRQ; i++) if (r[i] && m[i]) exp_q.push_back(DBITS'(i));
      pulse_irq(r);
      while (exp_q.size() > 0) begin
        pipeEmpty = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        pipeEmpty = 1'b1;
        wait_inta(12, seen, id);
        checks++; if (!seen || id !== exp_q[0]) begin errors++; $display("FAIL rand_it%0d_idn: got seen=%b idn=%0d exp seen=1 idn=%0d", it, seen, id, exp_q[0]); end
        void'(exp_q.pop_front());
        repeat ($urandom_range(1, 4)) tick();
        do_reti();
        if (!seen) exp_q.delete();
      end
      wait_inta(6, seen, id);
      checks++; if (seen) begin errors++; $display("FAIL rand_it%0d_extra: got an extra inta idn=%0d exp none", it, id); end
      checks++; if (pendOut !== (r & ~m)) begin errors++; $display("FAIL rand_it%0d_pend: got %b exp %b", it, pendOut, r & ~m); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_drain();
    test_mask();
    test_ie_drop();
    test_reset_in_ack();
    test_held_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
